// File: rtl/wish_pack_var_pkg.sv
// -----------------------------------------------------------------------------
// wish_pack_var_pkg
//   Shared definitions for the variable-ratio Wishbone-style word packer.
//   The tag bit positions are the same ones used by the integer reader and
//   writer blocks, so a tag produced upstream keeps its meaning here.
//
//   Contents
//     TGC_FIRST  tag bit marking the first word of a packet
//     TGC_LAST   tag bit marking the last word of a packet
// -----------------------------------------------------------------------------
package wish_pack_var_pkg;

   localparam int TGC_FIRST = 0;
   localparam int TGC_LAST  = 1;

endpackage

// File: rtl/wish_pack_var_outreg.sv
// -----------------------------------------------------------------------------
// wish_pack_var_outreg
//   Wide holding register that presents one packed group to the sink with a
//   stb/ack handshake. A group is loaded by a load pulse. It is then held
//   stable until the sink acknowledges it. When no new group replaces it on
//   that edge, the register is cleared.
//
//   Ports
//     clk_i     in   1          clock
//     rst_i     in   1          synchronous active-high reset
//     load      in   1          capture load_dat/load_sel/load_tgc this edge
//     load_dat  in   WIDE_W     packed data to capture
//     load_sel  in   NUM_PACK   lane-valid mask to capture
//     load_tgc  in   TGC_WIDTH  group tag to capture
//     ack       in   1          sink acknowledge (ignored while stb is low)
//     stb       out  1          register holds a group
//     dat       out  WIDE_W     held packed data
//     sel       out  NUM_PACK   held lane-valid mask
//     tgc       out  TGC_WIDTH  held group tag
//     free      out  1          register can take a new group this edge
// -----------------------------------------------------------------------------
module wish_pack_var_outreg #(
   parameter int WIDE_W    = 32,
   parameter int NUM_PACK  = 4,
   parameter int TGC_WIDTH = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load,
   input  logic [WIDE_W-1:0]    load_dat,
   input  logic [NUM_PACK-1:0]  load_sel,
   input  logic [TGC_WIDTH-1:0] load_tgc,
   input  logic                 ack,
   output logic                 stb,
   output logic [WIDE_W-1:0]    dat,
   output logic [NUM_PACK-1:0]  sel,
   output logic [TGC_WIDTH-1:0] tgc,
   output logic                 free
);

   // The register frees up either when it is empty or when the current
   // group is handed off on this same edge, which allows back-to-back groups.
   assign free = ~stb | ack;

   // ---- output stage: holding register ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stb <= 1'b0;
         dat <= '0;
         sel <= '0;
         tgc <= '0;
      end else if (load) begin
         stb <= 1'b1;
         dat <= load_dat;
         sel <= load_sel;
         tgc <= load_tgc;
      end else if (stb && ack) begin
         stb <= 1'b0;
         dat <= '0;
         sel <= '0;
         tgc <= '0;
      end
   end

endmodule

// File: rtl/wish_pack_var.sv
// -----------------------------------------------------------------------------
// wish_pack_var
//   Packs up to NUM_PACK narrow words from a pipelined Wishbone-style source
//   into one wide word for a Wishbone-style sink.
//   - A word tagged "last" can close a group early (FLUSH_ON_LAST).
//   - d_sel_o marks which lanes carry data.
//   - A "first" word arriving mid-group discards the partial group and
//     pulses err_o.
//   - The accumulator can hold one completed group while the output
//     register still holds the previous one, so streaming at full rate
//     never stalls when the sink acknowledges every cycle.
//
//   Parameters
//     DATA_WIDTH     width of one source word
//     NUM_PACK       source words per output word (>=2)
//     TGC_WIDTH      tag width (>=2); bit0 first, bit1 last, rest user bits
//     LITTLE_ENDIAN  1: first word in lane 0; 0: first word in top lane
//     FLUSH_ON_LAST  1: last-tagged word closes the group early
//
//   Ports
//     clk_i      in   1                    clock
//     rst_i      in   1                    synchronous active-high reset
//     s_cyc_i    in   1                    source cycle
//     s_stb_i    in   1                    source strobe
//     s_dat_i    in   DATA_WIDTH           source word
//     s_tgc_i    in   TGC_WIDTH            source tag
//     s_ack_o    out  1                    beat acknowledge, one cycle after accept
//     s_stall_o  out  1                    source stall (registered)
//     d_cyc_o    out  1                    sink cycle
//     d_stb_o    out  1                    sink strobe
//     d_dat_o    out  DATA_WIDTH*NUM_PACK  packed word
//     d_sel_o    out  NUM_PACK             lane valid mask
//     d_tgc_o    out  TGC_WIDTH            group tag
//     d_ack_i    in   1                    sink acknowledge
//     err_o      out  1                    one-cycle pulse after a resync discard
// -----------------------------------------------------------------------------
module wish_pack_var
   import wish_pack_var_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_PACK      = 4,
   parameter int TGC_WIDTH     = 2,
   parameter bit LITTLE_ENDIAN = 1'b0,
   parameter bit FLUSH_ON_LAST = 1'b1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           s_cyc_i,
   input  logic                           s_stb_i,
   input  logic [DATA_WIDTH-1:0]          s_dat_i,
   input  logic [TGC_WIDTH-1:0]           s_tgc_i,
   output logic                           s_ack_o,
   output logic                           s_stall_o,
   output logic                           d_cyc_o,
   output logic                           d_stb_o,
   output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
   output logic [NUM_PACK-1:0]            d_sel_o,
   output logic [TGC_WIDTH-1:0]           d_tgc_o,
   input  logic                           d_ack_i,
   output logic                           err_o
);

   localparam int WIDE_W = DATA_WIDTH * NUM_PACK;
   localparam int CNT_W  = $clog2(NUM_PACK + 1);
   localparam int LANE_W = $clog2(NUM_PACK);

   // Maps the arrival position of a word within its group to a lane.
   function automatic logic [LANE_W-1:0] lane_of(input logic [CNT_W-1:0] pos);
      logic [LANE_W-1:0] p;
      p = LANE_W'(pos);
      return LITTLE_ENDIAN ? p : (LANE_W'(NUM_PACK - 1) - p);
   endfunction

   // Accumulator state
   logic [CNT_W-1:0]     count;
   logic [WIDE_W-1:0]    acc_dat;
   logic [NUM_PACK-1:0]  acc_sel;
   logic                 first_bit;
   logic                 pend;
   logic [TGC_WIDTH-1:0] pend_tgc;
   logic                 ack_p1;
   logic                 err_p1;

   // Combinational view of the accepted word merged into the group
   logic                 accept;
   logic                 resync;
   logic                 out_free;
   logic                 complete;
   logic                 load;
   logic [CNT_W-1:0]     base_cnt;
   logic [CNT_W-1:0]     cnt_after;
   logic [LANE_W-1:0]    lane;
   logic [WIDE_W-1:0]    merged_dat;
   logic [NUM_PACK-1:0]  merged_sel;
   logic                 grp_first;
   logic [TGC_WIDTH-1:0] grp_tgc;
   logic [WIDE_W-1:0]    load_dat;
   logic [NUM_PACK-1:0]  load_sel;
   logic [TGC_WIDTH-1:0] load_tgc;

   // The stall output is the pending flag itself.
   // While a completed group waits in the accumulator, nothing new can be
   // accepted.
   assign accept = s_cyc_i & s_stb_i & ~pend;
   assign resync = accept & s_tgc_i[TGC_FIRST] & (count != '0);

   always_comb begin
      // A resync word restarts the group as if the accumulator were empty
      base_cnt   = resync ? '0 : count;
      cnt_after  = base_cnt + CNT_W'(1);
      lane       = lane_of(base_cnt);
      merged_dat = resync ? '0 : acc_dat;
      merged_sel = resync ? '0 : acc_sel;
      for (int i = 0; i < NUM_PACK; i++) begin
         if (lane == LANE_W'(i)) begin
            merged_dat[i*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
            merged_sel[i]                          = 1'b1;
         end
      end

      // Group tag: first bit from the opening word, everything else from
      // the word that closes the group
      grp_first          = (base_cnt == '0) ? s_tgc_i[TGC_FIRST] : first_bit;
      grp_tgc            = s_tgc_i;
      grp_tgc[TGC_FIRST] = grp_first;

      complete = accept & ((cnt_after == CNT_W'(NUM_PACK)) |
                           (FLUSH_ON_LAST & s_tgc_i[TGC_LAST]));

      // A pending group always goes to the output ahead of fresh data.
      // Fresh data cannot complete while a group is pending, because
      // accept is blocked.
      load     = out_free & (pend | complete);
      load_dat = pend ? acc_dat  : merged_dat;
      load_sel = pend ? acc_sel  : merged_sel;
      load_tgc = pend ? pend_tgc : grp_tgc;
   end

   // ---- accumulate stage ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count     <= '0;
         acc_dat   <= '0;
         acc_sel   <= '0;
         first_bit <= 1'b0;
         pend      <= 1'b0;
         pend_tgc  <= '0;
         ack_p1    <= 1'b0;
         err_p1    <= 1'b0;
      end else begin
         ack_p1 <= accept;
         err_p1 <= resync;
         if (accept) begin
            if (complete) begin
               count <= '0;
               if (out_free) begin
                  acc_dat <= '0;
                  acc_sel <= '0;
               end else begin
                  // Park the finished group until the output register drains
                  acc_dat  <= merged_dat;
                  acc_sel  <= merged_sel;
                  pend_tgc <= grp_tgc;
                  pend     <= 1'b1;
               end
            end else begin
               count     <= cnt_after;
               acc_dat   <= merged_dat;
               acc_sel   <= merged_sel;
               first_bit <= grp_first;
            end
         end else if (pend && out_free) begin
            pend    <= 1'b0;
            acc_dat <= '0;
            acc_sel <= '0;
         end
      end
   end

   assign s_ack_o   = ack_p1;
   assign s_stall_o = pend;
   assign err_o     = err_p1;

   wish_pack_var_outreg #(
      .WIDE_W    (WIDE_W),
      .NUM_PACK  (NUM_PACK),
      .TGC_WIDTH (TGC_WIDTH)
   ) u_outreg (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (load),
      .load_dat (load_dat),
      .load_sel (load_sel),
      .load_tgc (load_tgc),
      .ack      (d_ack_i),
      .stb      (d_stb_o),
      .dat      (d_dat_o),
      .sel      (d_sel_o),
      .tgc      (d_tgc_o),
      .free     (out_free)
   );

   assign d_cyc_o = d_stb_o;

endmodule

// File: tb/tb_wish_pack_var.sv
// -----------------------------------------------------------------------------
// tb_wish_pack_var
//   Drives two packers in parallel from one source: a big-endian one and a
//   little-endian one. Both are checked against a queue-based model of
//   groups, and directed cases are also pinned with literal expected words.
// -----------------------------------------------------------------------------
module tb_wish_pack_var;

   localparam int DW = 8;
   localparam int NP = 4;
   localparam int TW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            s_cyc, s_stb;
   logic [DW-1:0]   s_dat;
   logic [TW-1:0]   s_tgc;
   logic            d_ack;

   logic            s_ack0, s_stall0, d_cyc0, d_stb0, err0;
   logic [DW*NP-1:0] d_dat0;
   logic [NP-1:0]   d_sel0;
   logic [TW-1:0]   d_tgc0;
   logic            s_ack1, s_stall1, d_cyc1, d_stb1, err1;
   logic [DW*NP-1:0] d_dat1;
   logic [NP-1:0]   d_sel1;
   logic [TW-1:0]   d_tgc1;

   always #5 clk = ~clk;

   wish_pack_var #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW),
                   .LITTLE_ENDIAN(1'b0), .FLUSH_ON_LAST(1'b1)) dut_be (
      .clk_i(clk), .rst_i(rst),
      .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
      .s_ack_o(s_ack0), .s_stall_o(s_stall0),
      .d_cyc_o(d_cyc0), .d_stb_o(d_stb0), .d_dat_o(d_dat0), .d_sel_o(d_sel0),
      .d_tgc_o(d_tgc0), .d_ack_i(d_ack), .err_o(err0));

   wish_pack_var #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW),
                   .LITTLE_ENDIAN(1'b1), .FLUSH_ON_LAST(1'b1)) dut_le (
      .clk_i(clk), .rst_i(rst),
      .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
      .s_ack_o(s_ack1), .s_stall_o(s_stall1),
      .d_cyc_o(d_cyc1), .d_stb_o(d_stb1), .d_dat_o(d_dat1), .d_sel_o(d_sel1),
      .d_tgc_o(d_tgc1), .d_ack_i(d_ack), .err_o(err1));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
   endtask

   // ---------------- model ----------------
   typedef struct {
      logic [31:0] dat0, dat1;
      logic [3:0]  sel0, sel1;
      logic [1:0]  tgc;
   } grp_t;

   grp_t       out_q[$];
   logic [7:0] part[$];
   logic       part_first = 1'b0;
   logic       m_ack = 1'b0;
   logic       m_err = 1'b0;

   function automatic grp_t make_grp(input logic [7:0] w[$], input logic first, input logic last);
      grp_t g;
      g.dat0 = '0; g.dat1 = '0; g.sel0 = '0; g.sel1 = '0;
      for (int k = 0; k < w.size(); k++) begin
         g.dat0 = g.dat0 | (32'(w[k]) << (8 * (NP - 1 - k)));
         g.sel0 = g.sel0 | (4'b0001 << (NP - 1 - k));
         g.dat1 = g.dat1 | (32'(w[k]) << (8 * k));
         g.sel1 = g.sel1 | (4'b0001 << k);
      end
      g.tgc = {last, first};
      return g;
   endfunction

   always @(posedge clk) begin : mdl
      bit acc;
      if (rst) begin
         out_q.delete();
         part.delete();
         part_first = 1'b0;
         m_ack = 1'b0;
         m_err = 1'b0;
      end else begin
         // a second finished group waiting behind the output is the stall condition
         acc = s_cyc && s_stb && (out_q.size() < 2);
         if (out_q.size() > 0 && d_ack) void'(out_q.pop_front());
         m_ack = acc;
         m_err = 1'b0;
         if (acc) begin
            if (s_tgc[0] && part.size() != 0) begin
               part.delete();
               m_err = 1'b1;
            end
            if (part.size() == 0) part_first = s_tgc[0];
            part.push_back(s_dat);
            if (part.size() == NP || s_tgc[1]) begin
               out_q.push_back(make_grp(part, part_first, s_tgc[1]));
               part.delete();
            end
         end
      end
   end

   // ---------------- compare ----------------
   bit chk_on  = 1'b0;
   bit gap_on  = 1'b0;
   int cyc_n   = 0;
   int last_stb = -1;
   int stb_cnt = 0;
   int ack_cnt = 0;
   int err_cnt = 0;

   always @(posedge clk) cyc_n++;

   always @(negedge clk) begin : cmp
      grp_t g;
      logic e_stb;
      if (chk_on) begin
         e_stb = (out_q.size() > 0);
         if (e_stb) g = out_q[0];
         else begin
            g.dat0 = '0; g.dat1 = '0; g.sel0 = '0; g.sel1 = '0; g.tgc = '0;
         end
         chk("stb_be",   d_stb0,   e_stb);
         chk("cyc_be",   d_cyc0,   e_stb);
         chk("stb_le",   d_stb1,   e_stb);
         chk("dat_be",   d_dat0,   g.dat0);
         chk("sel_be",   d_sel0,   g.sel0);
         chk("tgc_be",   d_tgc0,   g.tgc);
         chk("dat_le",   d_dat1,   g.dat1);
         chk("sel_le",   d_sel1,   g.sel1);
         chk("tgc_le",   d_tgc1,   g.tgc);
         chk("s_ack",    s_ack0,   m_ack);
         chk("s_ack_le", s_ack1,   m_ack);
         chk("s_stall",  s_stall0, out_q.size() >= 2);
         chk("err",      err0,     m_err);
         chk("err_le",   err1,     m_err);
         if (err0) err_cnt++;
         if (gap_on) begin
            if (s_ack0) ack_cnt++;
            if (d_stb0) begin
               if (last_stb >= 0) chk("t5_gap", cyc_n - last_stb, 4);
               last_stb = cyc_n;
               stb_cnt++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic beat(input logic [7:0] d, input logic [1:0] t);
      int n;
      @(negedge clk);
      s_cyc = 1'b1; s_stb = 1'b1; s_dat = d; s_tgc = t;
      n = 0;
      while (s_stall0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("beat_wait", n < 50, 1'b1);
      @(posedge clk);
   endtask

   task automatic idle();
      #1;
      s_cyc = 1'b0; s_stb = 1'b0; s_dat = '0; s_tgc = '0;
   endtask

   task automatic expect_out(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] t);
      int n;
      n = 0;
      @(negedge clk);
      while (!d_stb0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_seen"}, d_stb0, 1'b1);
      chk({nm, "_dat_be"}, d_dat0, e0);
      chk({nm, "_dat_le"}, d_dat1, e1);
      chk({nm, "_sel_be"}, d_sel0, s0);
      chk({nm, "_sel_le"}, d_sel1, s1);
      chk({nm, "_tgc"},    d_tgc0, t);
   endtask

   task automatic reset_zero(input string nm);
      chk({nm, "_stb"},   d_stb0,   1'b0);
      chk({nm, "_dat"},   d_dat0,   32'h0);
      chk({nm, "_sel"},   d_sel0,   4'h0);
      chk({nm, "_ack"},   s_ack0,   1'b0);
      chk({nm, "_stall"}, s_stall0, 1'b0);
      chk({nm, "_err"},   err0,     1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; s_cyc = 1'b0; s_stb = 1'b0; s_dat = '0; s_tgc = '0; d_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_on = 1'b1;
      @(negedge clk);
      reset_zero("rst0");
      rst = 1'b0;

      // full group, first tag on the opening word
      beat(8'h01, 2'b01); beat(8'h02, 2'b00); beat(8'h03, 2'b00); beat(8'h04, 2'b00);
      idle();
      expect_out("t1", 32'h01020304, 32'h04030201, 4'hF, 4'hF, 2'b01);

      // early flush on last
      beat(8'h0A, 2'b01); beat(8'h0B, 2'b00); beat(8'h0C, 2'b10);
      idle();
      expect_out("t2", 32'h0A0B0C00, 32'h000C0B0A, 4'b1110, 4'b0111, 2'b11);

      // first and last on one word
      beat(8'h55, 2'b11);
      idle();
      expect_out("t2b", 32'h55000000, 32'h00000055, 4'b1000, 4'b0001, 2'b11);

      // resync on a misplaced first
      err_cnt = 0;
      beat(8'h11, 2'b01); beat(8'h12, 2'b00);
      beat(8'h21, 2'b01); beat(8'h22, 2'b00); beat(8'h23, 2'b00); beat(8'h24, 2'b00);
      idle();
      expect_out("t4", 32'h21222324, 32'h24232221, 4'hF, 4'hF, 2'b01);
      repeat (2) @(negedge clk);
      chk("t4_err_cnt", err_cnt, 1);

      // source cycle dropped mid-group keeps the partial group
      beat(8'h71, 2'b01); beat(8'h72, 2'b00);
      idle();
      repeat (3) @(negedge clk);
      beat(8'h73, 2'b00); beat(8'h74, 2'b00);
      idle();
      expect_out("t_cyc", 32'h71727374, 32'h74737271, 4'hF, 4'hF, 2'b01);

      // sink back-pressure: two groups, second one parked
      @(negedge clk);
      d_ack = 1'b0;
      beat(8'hA1, 2'b01); beat(8'hA2, 2'b00); beat(8'hA3, 2'b00); beat(8'hA4, 2'b00);
      beat(8'hB1, 2'b01); beat(8'hB2, 2'b00); beat(8'hB3, 2'b00); beat(8'hB4, 2'b00);
      idle();
      @(negedge clk);
      chk("t3_stall", s_stall0, 1'b1);
      chk("t3_hold_a", d_dat0, 32'hA1A2A3A4);
      repeat (10) @(negedge clk);
      chk("t3_hold_b", d_dat0, 32'hA1A2A3A4);
      chk("t3_stall_b", s_stall0, 1'b1);
      d_ack = 1'b1;
      chk("t3_g1_be", d_dat0, 32'hA1A2A3A4);
      chk("t3_g1_le", d_dat1, 32'hA4A3A2A1);
      expect_out("t3_g2", 32'hB1B2B3B4, 32'hB4B3B2B1, 4'hF, 4'hF, 2'b01);
      @(negedge clk);
      chk("t3_empty", d_stb0, 1'b0);
      chk("t3_unstall", s_stall0, 1'b0);

      // continuous stream at full rate
      last_stb = -1; stb_cnt = 0; ack_cnt = 0;
      gap_on = 1'b1;
      for (int i = 0; i < 16; i++)
         beat(8'(8'h60 + i), (i % 4 == 0) ? 2'b01 : 2'b00);
      idle();
      repeat (3) @(negedge clk);
      gap_on = 1'b0;
      chk("t5_groups", stb_cnt, 4);
      chk("t5_acks", ack_cnt, 16);

      // reset mid-group discards held words
      beat(8'h31, 2'b01); beat(8'h32, 2'b00);
      idle();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      reset_zero("t6_rst");
      rst = 1'b0;
      beat(8'h41, 2'b01); beat(8'h42, 2'b00); beat(8'h43, 2'b00); beat(8'h44, 2'b00);
      idle();
      expect_out("t6", 32'h41424344, 32'h44434241, 4'hF, 4'hF, 2'b01);

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
